light_monitor: RTL and testbench
================================

LIGHT_MONITOR -- requirements
Module: light_monitor

Interface
REQ-001 SHALL have port: clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: tick_1hz  in  1  one-clock enable pulse, once per second.
REQ-004 SHALL have ports: Rm, Ym, Gm, Rs, Ys, Gs, W  in  1 each  main/side lamp drives and walk lamp from the controller.
REQ-005 SHALL have port: fault_clr  in  1  clears sticky fault.
REQ-006 SHALL have port: phase  out  3  current decoded phase.
REQ-007 SHALL have port: phase_valid  out  1  high once a legal phase has been decoded since reset.
REQ-008 SHALL have port: dwell  out  5  seconds spent in the phase just left.
REQ-009 SHALL have port: dwell_valid  out  1  one-cycle pulse qualifying dwell.
REQ-010 SHALL have port: cycle_count  out  8  completed main-side cycles.
REQ-011 SHALL have port: fault  out  1  sticky fault flag.
REQ-012 SHALL have port: fault_code  out  2  code of first fault (0 none, 1 illegal lamp combo, 2 illegal sequence, 3 dwell timeout).

Function
REQ-013 SHALL register all seven lamp inputs into lamps_q every clock; all decode uses lamps_q only.
REQ-014 SHALL decode only these legal combos from lamps_q (all unlisted lamps 0):
- 0 MAIN_GO = Gm+Rs
- 1 MAIN_YEL = Ym+Rs
- 2 SIDE_GO = Rm+Gs
- 3 SIDE_YEL = Rm+Ys
- 4 WALK = Rm+Rs+W
REQ-015 SHALL treat any other lamps_q value as illegal: phase, phase_valid and dwell counter hold; raise fault code 1.
REQ-016 SHALL update phase on the edge after a legal decode differing from phase, giving 2-clock latency from lamp input change to phase output.
REQ-017 SHALL allow only transitions 0->1, 1->2, 1->4, 2->3, 3->0, 4->0; any other legal-to-legal change SHALL still update phase and raise fault code 2.
REQ-018 SHALL accept the first legal phase after reset (phase_valid 0->1) without a sequence check and without a dwell_valid pulse.
REQ-019 SHALL keep a 5-bit dwell counter incremented on tick_1hz while phase_valid=1, saturating at 31; reaching 31 SHALL raise fault code 3 once.
REQ-020 SHALL, on every phase update after the first, pulse dwell_valid for one cycle with dwell = counter value before the update, and load the counter with 0; a tick_1hz in that same cycle is discarded.
REQ-021 SHALL increment cycle_count on each 3->0 transition, wrapping 255->0.
REQ-022 SHALL latch fault=1 and fault_code on the first fault only; later faults do not change fault_code while fault=1.
REQ-023 SHALL clear fault and fault_code on fault_clr; if a new fault occurs in the same cycle, the new fault SHALL be latched instead.
REQ-024 SHALL keep phase and dwell outputs updating normally while fault=1.

Reset
REQ-025 SHALL on reset set lamps_q=0, phase=0, phase_valid=0, dwell=0, dwell_valid=0, dwell counter=0, cycle_count=0, fault=0, fault_code=0.
REQ-026 SHALL let reset override all other inputs, including mid-phase and mid-fault; the first legal phase after reset SHALL follow REQ-018.

Verification
REQ-027 SHALL cover legal cycle: 0 for 5 ticks, 1 for 2 ticks, 2 for 4 ticks, 3 for 2 ticks, then 0 -> dwell_valid pulses with dwell 5, 2, 4, 2; cycle_count=1; fault=0.
REQ-028 SHALL cover walk path: 0 -> 1 -> 4 (3 ticks) -> 0 -> dwell 3 reported at the 4->0 change; no fault.
REQ-029 SHALL cover illegal combo: Gm+Gs driven for 3 clocks -> fault=1, fault_code=1; phase holds; restored legal lamps continue without a new fault.
REQ-030 SHALL cover bad sequence 0->2 followed one cycle later by an illegal combo -> fault_code=2 latched, not overwritten by code 1.
REQ-031 SHALL cover timeout and clear: 40 ticks in phase 2 -> dwell saturates at 31, fault_code=3; fault_clr -> fault=0; fault_clr coincident with a 0->3 change -> fault=1, fault_code=2.
REQ-032 SHALL cover tick_1hz coincident with a phase change (tick discarded, new dwell starts at 0) and reset mid-phase (all outputs return to REQ-025 values).

Source files
------------

// File: rtl/light_monitor.sv
// Traffic-light monitor: decodes registered lamp drives into phases, times each phase,
// counts main/side cycles and latches the first illegal-combo, sequence or timeout fault.
module light_monitor (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       Rm,
    input  logic       Ym,
    input  logic       Gm,
    input  logic       Rs,
    input  logic       Ys,
    input  logic       Gs,
    input  logic       W,
    input  logic       fault_clr,
    output logic [2:0] phase,
    output logic       phase_valid,
    output logic [4:0] dwell,
    output logic       dwell_valid,
    output logic [7:0] cycle_count,
    output logic       fault,
    output logic [1:0] fault_code
);

    typedef enum logic [2:0] {
        PH_MAIN_GO  = 3'd0,
        PH_MAIN_YEL = 3'd1,
        PH_SIDE_GO  = 3'd2,
        PH_SIDE_YEL = 3'd3,
        PH_WALK     = 3'd4
    } phase_e;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_COMBO   = 2'd1,
        FC_SEQ     = 2'd2,
        FC_TIMEOUT = 2'd3
    } fault_e;

    localparam logic [4:0] DWELL_MAX = 5'd31;

    // Lamp vector order: {Rm, Ym, Gm, Rs, Ys, Gs, W}
    logic [6:0] lamps_q;
    phase_e     phase_q, phase_d;
    logic       phase_valid_q, phase_valid_d;
    logic [4:0] cnt_q, cnt_d;
    logic [4:0] dwell_q, dwell_d;
    logic       dwell_valid_q, dwell_valid_d;
    logic [7:0] cycle_q, cycle_d;
    logic       fault_q, fault_d;
    fault_e     code_q, code_d;

    logic       legal;
    phase_e     dec;
    fault_e     evt;

    function automatic logic seq_ok(input phase_e from_ph, input phase_e to_ph);
        case (from_ph)
            PH_MAIN_GO:  seq_ok = (to_ph == PH_MAIN_YEL);
            PH_MAIN_YEL: seq_ok = (to_ph == PH_SIDE_GO) || (to_ph == PH_WALK);
            PH_SIDE_GO:  seq_ok = (to_ph == PH_SIDE_YEL);
            PH_SIDE_YEL: seq_ok = (to_ph == PH_MAIN_GO);
            PH_WALK:     seq_ok = (to_ph == PH_MAIN_GO);
            default:     seq_ok = 1'b0;
        endcase
    endfunction

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        legal = 1'b1;
        dec   = PH_MAIN_GO;
        case (lamps_q)
            7'b0011000: dec = PH_MAIN_GO;
            7'b0101000: dec = PH_MAIN_YEL;
            7'b1000010: dec = PH_SIDE_GO;
            7'b1000100: dec = PH_SIDE_YEL;
            7'b1001001: dec = PH_WALK;
            default:    legal = 1'b0;
        endcase
    end

    always_comb begin
        phase_d       = phase_q;
        phase_valid_d = phase_valid_q;
        cnt_d         = cnt_q;
        dwell_d       = dwell_q;
        dwell_valid_d = 1'b0;
        cycle_d       = cycle_q;
        evt           = FC_NONE;

        if (legal && !phase_valid_q) begin
            phase_d       = dec;
            phase_valid_d = 1'b1;
            cnt_d         = '0;
        end else if (legal && (dec != phase_q)) begin
            // Phase change: report the dwell just completed; a coincident tick is dropped.
            phase_d       = dec;
            dwell_d       = cnt_q;
            dwell_valid_d = 1'b1;
            cnt_d         = '0;
            if (!seq_ok(phase_q, dec)) evt = FC_SEQ;
            if (phase_q == PH_SIDE_YEL && dec == PH_MAIN_GO) cycle_d = cycle_q + 8'd1;
        end else if (legal && tick_1hz && (cnt_q != DWELL_MAX)) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == DWELL_MAX - 5'd1) evt = FC_TIMEOUT;
        end

        // Dark lamps before the first legal phase (power-up) are not a fault.
        if (!legal && phase_valid_q) evt = FC_COMBO;
    end

    always_comb begin
        fault_d = fault_q;
        code_d  = code_q;
        if ((evt != FC_NONE) && (!fault_q || fault_clr)) begin
            fault_d = 1'b1;
            code_d  = evt;
        end else if (fault_clr) begin
            fault_d = 1'b0;
            code_d  = FC_NONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            lamps_q       <= '0;
            phase_q       <= PH_MAIN_GO;
            phase_valid_q <= 1'b0;
            cnt_q         <= '0;
            dwell_q       <= '0;
            dwell_valid_q <= 1'b0;
            cycle_q       <= '0;
            fault_q       <= 1'b0;
            code_q        <= FC_NONE;
        end else begin
            lamps_q       <= {Rm, Ym, Gm, Rs, Ys, Gs, W};
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            cnt_q         <= cnt_d;
            dwell_q       <= dwell_d;
            dwell_valid_q <= dwell_valid_d;
            cycle_q       <= cycle_d;
            fault_q       <= fault_d;
            code_q        <= code_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign dwell       = dwell_q;
    assign dwell_valid = dwell_valid_q;
    assign cycle_count = cycle_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;

endmodule

// File: tb/tb_light_monitor.sv
// Directed bench for light_monitor: legal cycle, walk path, faults, clear, tick/phase
// collision and reset mid-phase, with hand-computed expectations.
module tb_light_monitor;

    logic       clock = 1'b0;
    logic       reset, tick_1hz, fault_clr;
    logic       Rm, Ym, Gm, Rs, Ys, Gs, W;
    logic [2:0] phase;
    logic       phase_valid, dwell_valid, fault;
    logic [4:0] dwell;
    logic [7:0] cycle_count;
    logic [1:0] fault_code;

    int errors = 0;
    int checks = 0;

    light_monitor dut (
        .clock       (clock),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .Rm          (Rm),
        .Ym          (Ym),
        .Gm          (Gm),
        .Rs          (Rs),
        .Ys          (Ys),
        .Gs          (Gs),
        .W           (W),
        .fault_clr   (fault_clr),
        .phase       (phase),
        .phase_valid (phase_valid),
        .dwell       (dwell),
        .dwell_valid (dwell_valid),
        .cycle_count (cycle_count),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clock = ~clock;

    // Lamp patterns {Rm,Ym,Gm,Rs,Ys,Gs,W}; 7 is an illegal Gm+Gs drive.
    task automatic set_lamps(input int p);
        case (p)
            0: {Rm, Ym, Gm, Rs, Ys, Gs, W} = 7'b0011000;
            1: {Rm, Ym, Gm, Rs, Ys, Gs, W} = 7'b0101000;
            2: {Rm, Ym, Gm, Rs, Ys, Gs, W} = 7'b1000010;
            3: {Rm, Ym, Gm, Rs, Ys, Gs, W} = 7'b1000100;
            4: {Rm, Ym, Gm, Rs, Ys, Gs, W} = 7'b1001001;
            default: {Rm, Ym, Gm, Rs, Ys, Gs, W} = 7'b0010010;
        endcase
    endtask

    task automatic clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            tick_1hz = 1'b1;
            clk(1);
            tick_1hz = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        fault_clr = 1'b1;
        clk(1);
        fault_clr = 1'b0;
    endtask

    // Change lamps and expect the phase update two edges later with the given dwell report.
    task automatic goto(input int p, input int exp_dwell);
        set_lamps(p);
        clk(2);
        check($sformatf("phase_%0d", p), 32'(phase), 32'(p));
        check($sformatf("dv_%0d", p), 32'(dwell_valid), 32'd1);
        check($sformatf("dwell_%0d", p), 32'(dwell), 32'(exp_dwell));
        clk(1);
        check($sformatf("dv_end_%0d", p), 32'(dwell_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; tick_1hz = 1'b0; fault_clr = 1'b0;
        {Rm, Ym, Gm, Rs, Ys, Gs, W} = '0;
        clk(3);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_pv", 32'(phase_valid), 32'd0);
        check("rst_dwell", 32'(dwell), 32'd0);
        check("rst_dv", 32'(dwell_valid), 32'd0);
        check("rst_cc", 32'(cycle_count), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_code", 32'(fault_code), 32'd0);

        // Legal cycle 0(5) 1(2) 2(4) 3(2) -> 0
        set_lamps(0);
        reset = 1'b0;
        clk(1);
        check("first_pv_lat", 32'(phase_valid), 32'd0);
        clk(1);
        check("first_pv", 32'(phase_valid), 32'd1);
        check("first_phase", 32'(phase), 32'd0);
        check("first_no_dv", 32'(dwell_valid), 32'd0);
        tick(5); goto(1, 5);
        tick(2); goto(2, 2);
        tick(4); goto(3, 4);
        tick(2); goto(0, 2);
        check("cyc_cc", 32'(cycle_count), 32'd1);
        check("cyc_fault", 32'(fault), 32'd0);

        // Walk path 0 -> 1 -> 4 (3 ticks) -> 0
        goto(1, 0);
        goto(4, 0);
        tick(3); goto(0, 3);
        check("walk_fault", 32'(fault), 32'd0);
        check("walk_cc", 32'(cycle_count), 32'd1);

        // Illegal combo held 3 clocks
        set_lamps(7);
        clk(3);
        check("combo_fault", 32'(fault), 32'd1);
        check("combo_code", 32'(fault_code), 32'd1);
        check("combo_hold", 32'(phase), 32'd0);
        set_lamps(0);
        clk(2);
        check("combo_back_phase", 32'(phase), 32'd0);
        check("combo_back_dv", 32'(dwell_valid), 32'd0);
        pulse_clr();
        check("combo_clr", 32'(fault), 32'd0);
        check("combo_clr_code", 32'(fault_code), 32'd0);
        tick(1); clk(2);
        check("combo_no_new", 32'(fault), 32'd0);

        // Bad sequence 0 -> 2, illegal combo one cycle later must not overwrite code 2
        set_lamps(2);
        clk(1);
        set_lamps(7);
        clk(1);
        check("seq_phase", 32'(phase), 32'd2);
        check("seq_fault", 32'(fault), 32'd1);
        check("seq_code", 32'(fault_code), 32'd2);
        check("seq_dwell", 32'(dwell), 32'd1);
        clk(2);
        check("seq_code_kept", 32'(fault_code), 32'd2);
        set_lamps(2);
        clk(2);
        pulse_clr();
        check("seq_clr", 32'(fault), 32'd0);

        // Timeout: 31st tick saturates and faults
        tick(30);
        check("to_before", 32'(fault), 32'd0);
        tick(10);
        check("to_fault", 32'(fault), 32'd1);
        check("to_code", 32'(fault_code), 32'd3);
        goto(3, 31);
        goto(0, 0);
        check("to_cc", 32'(cycle_count), 32'd2);
        check("to_code_kept", 32'(fault_code), 32'd3);

        // fault_clr coincident with bad 0 -> 3 latches the new fault
        set_lamps(3);
        clk(1);
        fault_clr = 1'b1;
        clk(1);
        fault_clr = 1'b0;
        check("clrseq_phase", 32'(phase), 32'd3);
        check("clrseq_fault", 32'(fault), 32'd1);
        check("clrseq_code", 32'(fault_code), 32'd2);
        pulse_clr();
        check("clr_fault", 32'(fault), 32'd0);
        check("clr_code", 32'(fault_code), 32'd0);

        // Tick coincident with the 3 -> 0 change is discarded
        set_lamps(0);
        clk(1);
        tick_1hz = 1'b1;
        clk(1);
        tick_1hz = 1'b0;
        check("tc_phase", 32'(phase), 32'd0);
        check("tc_dv", 32'(dwell_valid), 32'd1);
        check("tc_dwell", 32'(dwell), 32'd0);
        check("tc_cc", 32'(cycle_count), 32'd3);
        tick(1); goto(1, 1);

        // Reset mid-phase and mid-fault
        tick(2);
        set_lamps(7);
        clk(3);
        check("pre_rst_fault", 32'(fault), 32'd1);
        reset = 1'b1;
        clk(2);
        check("mid_rst_phase", 32'(phase), 32'd0);
        check("mid_rst_pv", 32'(phase_valid), 32'd0);
        check("mid_rst_dwell", 32'(dwell), 32'd0);
        check("mid_rst_dv", 32'(dwell_valid), 32'd0);
        check("mid_rst_cc", 32'(cycle_count), 32'd0);
        check("mid_rst_fault", 32'(fault), 32'd0);
        check("mid_rst_code", 32'(fault_code), 32'd0);
        set_lamps(2);
        reset = 1'b0;
        clk(1);
        check("rst2_pv_lat", 32'(phase_valid), 32'd0);
        clk(1);
        check("rst2_pv", 32'(phase_valid), 32'd1);
        check("rst2_phase", 32'(phase), 32'd2);
        check("rst2_no_dv", 32'(dwell_valid), 32'd0);
        check("rst2_no_fault", 32'(fault), 32'd0);
        goto(3, 0);
        goto(0, 0);
        check("rst2_cc", 32'(cycle_count), 32'd1);
        check("rst2_fault_end", 32'(fault), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
